// File: rtl/perip_div_pkg.sv
// Shared definitions for the divider-peripheral bus master: register map,
// FSM state type, the registered bus payload and a helper that builds each strobe.
package perip_div_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned WDATA_W = 16;
    localparam int unsigned RDATA_W = 32;
    localparam int unsigned GAP_W   = 4;
    localparam int unsigned POLL_W  = 16;

    localparam logic [ADDR_W-1:0]  ADDR_A      = 5'h04;
    localparam logic [ADDR_W-1:0]  ADDR_B      = 5'h08;
    localparam logic [ADDR_W-1:0]  ADDR_INIT   = 5'h0C;
    localparam logic [ADDR_W-1:0]  ADDR_RESULT = 5'h10;
    localparam logic [ADDR_W-1:0]  ADDR_DONE   = 5'h14;
    localparam logic [WDATA_W-1:0] INIT_CMD    = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_A,
        ST_WR_B,
        ST_START,
        ST_POLL,
        ST_RESULT,
        ST_RESP,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic               cs;
        logic               rd;
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [WDATA_W-1:0] wdata;
    } bus_t;

    // Bus payload for the strobe issued while sitting in state s.
    function automatic bus_t bus_for(state_e s, logic [WDATA_W-1:0] a, logic [WDATA_W-1:0] b);
        bus_t r;
        r    = '0;
        r.cs = 1'b1;
        case (s)
            ST_WR_A:   begin r.wr = 1'b1; r.addr = ADDR_A;    r.wdata = a;        end
            ST_WR_B:   begin r.wr = 1'b1; r.addr = ADDR_B;    r.wdata = b;        end
            ST_START:  begin r.wr = 1'b1; r.addr = ADDR_INIT; r.wdata = INIT_CMD; end
            ST_POLL:   begin r.rd = 1'b1; r.addr = ADDR_DONE;                     end
            ST_RESULT: begin r.rd = 1'b1; r.addr = ADDR_RESULT;                   end
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/perip_div_master.sv
// Bus initiator that runs a full divide sequence on the memory-mapped divider
// (write A, B, INIT, poll DONE, read RESULT) and returns the result to the host.
module perip_div_master
    import perip_div_pkg::*;
#(
    parameter int unsigned IDLE_GAP  = 1,
    parameter int unsigned MAX_POLLS = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [WDATA_W-1:0]  req_a,
    input  logic [WDATA_W-1:0]  req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [RDATA_W-1:0]  resp_data,
    output logic                resp_timeout,
    output logic                busy,
    output logic                cs,
    output logic                rd,
    output logic                wr,
    output logic [ADDR_W-1:0]   addr,
    output logic [WDATA_W-1:0]  d_out,
    input  logic [RDATA_W-1:0]  d_in
);

    state_e               state_q, state_d, ret_q, ret_d, next_c;
    bus_t                 bus_q, bus_d;
    logic [WDATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [POLL_W-1:0]    poll_q, poll_d;
    logic [POLL_W:0]      polls_done_c;
    logic                 go_c;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_timeout_q, resp_timeout_d;
    logic [RDATA_W-1:0]   resp_data_q, resp_data_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;

    // State and output registers; reset releases the bus immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ret_q          <= ST_IDLE;
            bus_q          <= '0;
            a_q            <= '0;
            b_q            <= '0;
            gap_q          <= '0;
            poll_q         <= '0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            resp_data_q    <= '0;
            req_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ret_q          <= ret_d;
            bus_q          <= bus_d;
            a_q            <= a_d;
            b_q            <= b_d;
            gap_q          <= gap_d;
            poll_q         <= poll_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
            resp_data_q    <= resp_data_d;
            req_ready_q    <= req_ready_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state logic: bus payload is computed one cycle ahead so every strobe is a register.
    always_comb begin
        state_d        = state_q;
        ret_d          = ret_q;
        bus_d          = '0;
        bus_d.addr     = bus_q.addr;
        bus_d.wdata    = bus_q.wdata;
        a_d            = a_q;
        b_d            = b_q;
        gap_d          = gap_q;
        poll_d         = poll_q;
        resp_valid_d   = resp_valid_q;
        resp_timeout_d = resp_timeout_q;
        resp_data_d    = resp_data_q;
        next_c         = ST_IDLE;
        go_c           = 1'b0;
        polls_done_c   = (POLL_W+1)'(poll_q) + (POLL_W+1)'(1);

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    poll_d  = '0;
                    bus_d   = bus_for(ST_WR_A, req_a, req_b);
                    state_d = ST_WR_A;
                end
            end
            ST_WR_A:  begin next_c = ST_WR_B;  go_c = 1'b1; end
            ST_WR_B:  begin next_c = ST_START; go_c = 1'b1; end
            ST_START: begin next_c = ST_POLL;  go_c = 1'b1; poll_d = '0; end
            ST_POLL: begin
                poll_d = POLL_W'(polls_done_c);
                if (d_in[0]) begin
                    next_c = ST_RESULT;
                    go_c   = 1'b1;
                end else if (polls_done_c < (POLL_W+1)'(MAX_POLLS)) begin
                    next_c = ST_POLL;
                    go_c   = 1'b1;
                end else begin
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                    resp_data_d    = '0;
                    state_d        = ST_RESP;
                end
            end
            ST_RESULT: begin
                resp_valid_d   = 1'b1;
                resp_timeout_d = 1'b0;
                resp_data_d    = d_in;
                state_d        = ST_RESP;
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ret_q;
                    bus_d   = bus_for(ret_q, a_q, b_q);
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Idle gap inserted between consecutive strobes (never after RESULT).
        if (go_c) begin
            if (IDLE_GAP == 0) begin
                state_d = next_c;
                bus_d   = bus_for(next_c, a_q, b_q);
            end else begin
                state_d = ST_GAP;
                ret_d   = next_c;
                gap_d   = GAP_W'(IDLE_GAP - 1);
            end
        end

        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign cs           = bus_q.cs;
    assign rd           = bus_q.rd;
    assign wr           = bus_q.wr;
    assign addr         = bus_q.addr;
    assign d_out        = bus_q.wdata;
    assign req_ready    = req_ready_q;
    assign busy         = busy_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_perip_div_master.sv
// Self-checking bench: behavioural divider slave, bus-transaction log and a
// cycle-level reference of the expected access sequence.
`timescale 1ns/1ps
module tb_perip_div_master;

    localparam int unsigned GAP1 = 1;
    localparam int unsigned GAP2 = 2;
    localparam int unsigned MP2  = 4;

    typedef struct {
        int          cyc;
        bit          rd;
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1, resp_timeout, busy;
    logic        cs, rd, wr;
    logic [15:0] req_a = '0, req_b = '0, d_out;
    logic [4:0]  addr;
    logic [31:0] resp_data, d_in;

    logic        t_req_valid = 1'b0, t_req_ready, t_resp_valid, t_resp_ready = 1'b1, t_resp_timeout, t_busy;
    logic        t_cs, t_rd, t_wr;
    logic [15:0] t_req_a = '0, t_req_b = '0, t_d_out;
    logic [4:0]  t_addr;
    logic [31:0] t_resp_data, t_d_in;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_at = 1;
    int   polls_seen = 0;
    logic [15:0] sa = '0, sb = '0;
    ev_t  log_q[$];
    ev_t  log2_q[$];
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    perip_div_master #(.IDLE_GAP(GAP1), .MAX_POLLS(64)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_timeout(resp_timeout), .busy(busy),
        .cs(cs), .rd(rd), .wr(wr), .addr(addr), .d_out(d_out), .d_in(d_in)
    );

    perip_div_master #(.IDLE_GAP(GAP2), .MAX_POLLS(MP2)) u_dut_to (
        .clk(clk), .reset_n(reset_n), .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_a(t_req_a), .req_b(t_req_b), .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
        .resp_data(t_resp_data), .resp_timeout(t_resp_timeout), .busy(t_busy),
        .cs(t_cs), .rd(t_rd), .wr(t_wr), .addr(t_addr), .d_out(t_d_out), .d_in(t_d_in)
    );

    function automatic logic [31:0] div_model(logic [15:0] a, logic [15:0] b);
        if (b == 16'h0) return {16'hFFFF, a};
        return {16'(a % b), 16'(a / b)};
    endfunction

    function automatic ev_t mk(int c, bit r, bit w, logic [4:0] ad, logic [15:0] d);
        ev_t e;
        e.cyc = c; e.rd = r; e.wr = w; e.addr = ad; e.wdata = d;
        return e;
    endfunction

    // Expected accesses relative to the accept cycle: n DONE polls, then the RESULT read.
    task automatic build_exp(logic [15:0] a, logic [15:0] b, int n, int g);
        exp_q.delete();
        exp_q.push_back(mk(1,       0, 1, 5'h04, a));
        exp_q.push_back(mk(1 + g,   0, 1, 5'h08, b));
        exp_q.push_back(mk(1 + 2*g, 0, 1, 5'h0C, 16'h0001));
        for (int k = 0; k < n; k++) exp_q.push_back(mk(1 + 3*g + k*g, 1, 0, 5'h14, 16'h0));
        exp_q.push_back(mk(1 + 3*g + n*g, 1, 0, 5'h10, 16'h0));
    endtask

    // Divider slave: DONE returns 1 from poll number done_at on; upper bits are noise.
    always_comb begin
        d_in = '0;
        if (rd && addr == 5'h14) d_in = (polls_seen + 1 >= done_at) ? 32'hFFFF_FFFF : 32'hFFFF_FFFE;
        else if (rd && addr == 5'h10) d_in = div_model(sa, sb);
    end
    assign t_d_in = 32'hFFFF_FFFE;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cs) log_q.push_back(mk(cyc, rd, wr, addr, d_out));
        if (t_cs) log2_q.push_back(mk(cyc, t_rd, t_wr, t_addr, t_d_out));
        if (cs && wr && addr == 5'h04) sa <= d_out;
        if (cs && wr && addr == 5'h08) sb <= d_out;
        if (cs && wr && addr == 5'h0C) polls_seen <= 0;
        else if (cs && rd && addr == 5'h14) polls_seen <= polls_seen + 1;
    end

    task automatic issue_req(logic [15:0] a, logic [15:0] b, output int acc);
        @(negedge clk);
        req_valid = 1'b1; req_a = a; req_b = b; acc = -1;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin acc = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int rc, output logic [31:0] data, output logic to, output bit ok);
        ok = 0; rc = -1; data = '0; to = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (resp_valid) begin rc = cyc; data = resp_data; to = resp_timeout; ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cs, rd, wr, busy, resp_valid, resp_timeout} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {cs, rd, wr, busy, resp_valid, resp_timeout});
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++;
        if ({addr, d_out, resp_data} !== 53'h0) begin
            errors++; $display("FAIL reset_data got addr=%h d_out=%h resp=%h exp 0", addr, d_out, resp_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got ready=%b busy=%b exp 1/0", req_ready, busy);
        end
    endtask

    task automatic test_sequences();
        logic [15:0] a, b;
        int n, acc, rc;
        logic [31:0] data;
        logic to;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom); b = 16'($urandom_range(1, 300)); n = $urandom_range(1, 6);
            if (i == 0) begin a = 16'h000F; b = 16'h0005; n = 1; end
            if (i == 1) n = 17;
            if (i == 2) b = 16'h0000;
            done_at = n;
            log_q.delete();
            issue_req(a, b, acc);
            wait_resp(rc, data, to, ok);
            build_exp(a, b, n, GAP1 + 1);
            checks++;
            if (acc < 0 || !ok) begin errors++; $display("FAIL seq%0d handshake got acc=%0d ok=%0d exp accepted+resp", i, acc, ok); end
            checks++;
            if (log_q.size() != exp_q.size()) begin
                errors++; $display("FAIL seq%0d log_len got %0d exp %0d", i, log_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < log_q.size(); k++) begin
                checks++;
                if (log_q[k].cyc - acc != exp_q[k].cyc || log_q[k].rd !== exp_q[k].rd || log_q[k].wr !== exp_q[k].wr ||
                    log_q[k].addr !== exp_q[k].addr || (exp_q[k].wr && log_q[k].wdata !== exp_q[k].wdata)) begin
                    errors++;
                    $display("FAIL seq%0d bus[%0d] got c=%0d r=%0d w=%0d a=%h d=%h exp c=%0d r=%0d w=%0d a=%h d=%h", i, k,
                             log_q[k].cyc - acc, log_q[k].rd, log_q[k].wr, log_q[k].addr, log_q[k].wdata,
                             exp_q[k].cyc, exp_q[k].rd, exp_q[k].wr, exp_q[k].addr, exp_q[k].wdata);
                end
            end
            checks++;
            if (rc - acc != 2 + (3 + n) * int'(GAP1 + 1) || data !== div_model(a, b) || to !== 1'b0) begin
                errors++; $display("FAIL seq%0d resp got c=%0d d=%h to=%b exp c=%0d d=%h to=0", i, rc - acc, data, to,
                                   2 + (3 + n) * int'(GAP1 + 1), div_model(a, b));
            end
        end
    endtask

    task automatic test_timeout();
        int acc;
        bit ok;
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom);
        log2_q.delete();
        @(negedge clk);
        t_req_valid = 1'b1; t_req_a = a; t_req_b = b; acc = -1; ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (t_req_ready) begin acc = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        t_req_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (t_resp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok || t_resp_timeout !== 1'b1 || t_resp_data !== 32'h0) begin
            errors++; $display("FAIL timeout_resp got ok=%0d to=%b d=%h exp 1/1/0", ok, t_resp_timeout, t_resp_data);
        end
        @(negedge clk);
        build_exp(a, b, MP2, GAP2 + 1);
        void'(exp_q.pop_back());
        checks++;
        if (log2_q.size() != exp_q.size()) begin
            errors++; $display("FAIL timeout_log_len got %0d exp %0d", log2_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < log2_q.size(); k++) begin
            checks++;
            if (log2_q[k].cyc - acc != exp_q[k].cyc || log2_q[k].rd !== exp_q[k].rd || log2_q[k].addr !== exp_q[k].addr) begin
                errors++; $display("FAIL timeout_bus[%0d] got c=%0d a=%h exp c=%0d a=%h", k,
                                   log2_q[k].cyc - acc, log2_q[k].addr, exp_q[k].cyc, exp_q[k].addr);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        bit ok;
        logic [31:0] d0;
        logic to0;
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom_range(1, 1000));
        done_at = 2; resp_ready = 1'b0; ok = 0;
        issue_req(a, b, acc);
        for (int i = 0; i < 200; i++) begin
            if (resp_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        d0 = resp_data; to0 = resp_timeout;
        checks++;
        if (!ok || d0 !== div_model(a, b) || to0 !== 1'b0) begin
            errors++; $display("FAIL bp_resp got ok=%0d d=%h to=%b exp d=%h to=0", ok, d0, to0, div_model(a, b));
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== d0 || resp_timeout !== to0 || req_ready !== 1'b0 || cs !== 1'b0) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h to=%b rdy=%b cs=%b exp 1/%h/%b/0/0", i,
                                   resp_valid, resp_data, resp_timeout, req_ready, cs, d0, to0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got v=%b rdy=%b busy=%b exp 0/1/0", resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        int acc, rc, n0;
        bit ok;
        logic [31:0] data;
        logic to;
        logic [15:0] a, b;
        done_at = 1000; ok = 0;
        issue_req(16'h1234, 16'h0042, acc);
        for (int i = 0; i < 100; i++) begin
            if (cs && rd && addr == 5'h14) begin ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || {cs, rd, wr, resp_valid, busy} !== 5'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_async got ok=%0d cs=%b rd=%b wr=%b v=%b busy=%b rdy=%b exp 0s,rdy=1",
                               ok, cs, rd, wr, resp_valid, busy, req_ready);
        end
        n0 = log_q.size();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (log_q.size() != n0 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_quiet got strobes=%0d busy=%b v=%b exp 0/0/0", log_q.size() - n0, busy, resp_valid);
        end
        a = 16'($urandom); b = 16'($urandom_range(1, 50));
        done_at = 2;
        log_q.delete();
        issue_req(a, b, acc);
        wait_resp(rc, data, to, ok);
        build_exp(a, b, 2, GAP1 + 1);
        checks++;
        if (!ok || log_q.size() != exp_q.size() || data !== div_model(a, b) || to !== 1'b0 ||
            rc - acc != 2 + 5 * int'(GAP1 + 1)) begin
            errors++; $display("FAIL rst_mid_after got ok=%0d len=%0d d=%h to=%b c=%0d exp len=%0d d=%h c=%0d",
                               ok, log_q.size(), data, to, rc - acc, exp_q.size(), div_model(a, b), 2 + 5 * int'(GAP1 + 1));
        end
    endtask

    task automatic test_ignore_busy();
        int acc, rc;
        bit ok;
        logic [31:0] data;
        logic to;
        logic [15:0] a, b;
        a = 16'($urandom); b = 16'($urandom_range(1, 400));
        done_at = 3;
        log_q.delete();
        issue_req(a, b, acc);
        req_a = ~a; req_b = b + 16'd7;
        for (int i = 0; i < 6; i++) begin
            req_valid = i[0];
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL busy_ready[%0d] got rdy=%b busy=%b exp 0/1", i, req_ready, busy);
            end
        end
        req_valid = 1'b0;
        wait_resp(rc, data, to, ok);
        repeat (6) @(negedge clk);
        build_exp(a, b, 3, GAP1 + 1);
        checks++;
        if (!ok || log_q.size() != exp_q.size() || data !== div_model(a, b) || busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignore got ok=%0d len=%0d d=%h busy=%b exp len=%0d d=%h busy=0",
                               ok, log_q.size(), data, busy, exp_q.size(), div_model(a, b));
        end
        for (int k = 0; k < 2 && k < log_q.size(); k++) begin
            checks++;
            if (log_q[k].wdata !== exp_q[k].wdata) begin
                errors++; $display("FAIL busy_operand[%0d] got %h exp %h", k, log_q[k].wdata, exp_q[k].wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequences();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_ignore_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/perip_div_master.md
Name: perip_div_master

Overview:
- Bus initiator that drives a memory-mapped divider peripheral (cs/addr/rd/wr slave with A=0x04, B=0x08, INIT=0x0C, RESULT=0x10, DONE=0x14).
- Accepts a {A,B} command on a valid/ready host port, then runs the full sequence: write A, write B, write INIT, poll DONE, read RESULT.
- Returns the 32-bit result on a valid/ready response port.
- Sits between a host/CPU-side command source and the divider slave, replacing software polling.

Parameters:
- IDLE_GAP, 1, idle bus cycles (cs=rd=wr=0) inserted after every strobe except the RESULT read; legal range 0..15.
- MAX_POLLS, 64, number of DONE reads reading 0 before a timeout is declared; legal range 1..65535.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  host command valid.
- req_ready  out  1  master can accept a command (high only in IDLE).
- req_a  in  16  operand A.
- req_b  in  16  operand B.
- resp_valid  out  1  response valid.
- resp_ready  in  1  host accepts the response.
- resp_data  out  32  divider RESULT register contents (0 on timeout).
- resp_timeout  out  1  DONE never read as 1 within MAX_POLLS polls.
- busy  out  1  high in every state except IDLE.
- cs  out  1  slave chip select.
- rd  out  1  slave read strobe.
- wr  out  1  slave write strobe.
- addr  out  5  slave register address.
- d_out  out  16  write data to slave.
- d_in  in  32  read data from slave; valid combinationally during the rd cycle.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. Outputs: cs=rd=wr=0, addr=0, d_out=0, resp_valid=0, resp_data=0, resp_timeout=0, busy=0, req_ready=1 (after the first clock edge out of reset or immediately; combinational from IDLE). Poll and gap counters cleared.
- Reset mid-operation aborts the sequence: the bus is released in the same instant, no further strobes, no response.
- All bus outputs are registered. Each access is a single-cycle strobe with cs=1 and exactly one of rd/wr=1. addr/d_out are stable for the whole strobe. Reads capture d_in at the rising edge that ends the strobe cycle.
- Operands are latched on the accept edge (req_valid && req_ready). Later changes to req_a/req_b are ignored.
- States:
  - IDLE -> WR_A on accept.
  - WR_A: addr=0x04, d_out=A, wr=1.
  - WR_B: addr=0x08, d_out=B.
  - START: addr=0x0C, d_out=16'h0001.
  - POLL: addr=0x14, rd=1.
  - RESULT: addr=0x10, rd=1.
  - RESP.
- Every strobe state except RESULT is followed by IDLE_GAP idle cycles before the next strobe (gap counter, 4 bits).
- POLL:
  - d_in[0]=1 -> RESULT, entered directly after the gap.
  - d_in[0]=0 with poll count < MAX_POLLS -> repeat POLL after the gap.
  - Otherwise -> RESP with resp_timeout=1 and resp_data=0; RESULT is not read.
- RESULT: d_in is captured into resp_data, resp_timeout=0, then -> RESP. resp_valid rises in the cycle after the capture edge.
- RESP: resp_valid, resp_data and resp_timeout are held stable until resp_valid && resp_ready.
  - On that edge: resp_valid=0, then -> IDLE.
  - req_ready rises in the next cycle; there is no back-to-back accept in the same cycle.
- Timing with IDLE_GAP=1, accept edge ending cycle 0, DONE=1 on the first poll:
  - Strobes in cycles 1 (A), 3 (B), 5 (INIT), 7 (POLL), 9 (RESULT).
  - resp_valid first high in cycle 10.
  - Each extra poll adds IDLE_GAP+1 cycles.
- The master does not interpret operands (B=0 is passed through). Only d_in[0] of DONE is significant.
- req_valid asserted while busy is ignored and not queued.

Decomposition:
- Shared package perip_div_pkg:
  - Register address constants ADDR_A=5'h04, ADDR_B=5'h08, ADDR_INIT=5'h0C, ADDR_RESULT=5'h10, ADDR_DONE=5'h14.
  - INIT_CMD=16'h0001.
  - State enum type.
- No sub-module is required. A behavioural divider slave model for the bench lives in the test directory, not in the RTL.

Test Plan:
- Reset then req A=0x000F, B=0x0005, slave DONE=1 at first poll, RESULT=0x0000_0003:
  - Bus sequence: wr 0x04/0x000F, wr 0x08/0x0005, wr 0x0C/0x0001, rd 0x14, rd 0x10, at cycles 1,3,5,7,9.
  - resp_valid at cycle 10 with resp_data=0x0000_0003, resp_timeout=0.
- Slave asserts DONE only on the 17th poll:
  - Exactly 17 DONE reads, then one RESULT read.
  - Response appears 16*(IDLE_GAP+1) cycles later than in the first scenario.
- DONE held 0, MAX_POLLS=4:
  - Exactly 4 DONE reads and no RESULT read.
  - resp_timeout=1, resp_data=0.
- resp_ready held low for 10 cycles:
  - resp_valid, resp_data and resp_timeout stay stable; req_ready=0 and cs=0 throughout.
  - On release, req_ready=1 in the following cycle.
- reset_n pulsed low during the POLL gap:
  - cs/rd/wr/resp_valid go 0 asynchronously; state returns to IDLE.
  - A new request afterwards completes normally.
- req_valid pulsed while busy, and req_a changed after the accept edge:
  - The extra request is ignored.
  - Bus data still carries the operands latched at the accept edge.
